// File: rtl/sfr_access_arbiter.sv
// sfr_access_arbiter: round-robin sharing of the single-port SFR file among NUM_REQ masters
module sfr_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ = 2,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id,
    output logic [ADDR_WIDTH-1:0]         sfr_address,
    output logic [DATA_WIDTH-1:0]         sfr_write_data,
    output logic                          sfr_we,
    output logic                          sfr_re,
    input  logic [DATA_WIDTH-1:0]         sfr_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t                state_q;
    logic [IDW-1:0]        rr_q;
    logic [IDW-1:0]        cand;
    logic [IDW-1:0]        win;
    logic                  any_valid;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    // Scan from rr_q+1 upward; walking offsets high-to-low lets the nearest requester overwrite the rest
    always_comb begin
        cand = '0;
        win = '0;
        any_valid = 1'b0;
        win_write = 1'b0;
        win_addr = '0;
        win_wdata = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDW'((int'(rr_q) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                win = cand;
                any_valid = 1'b1;
                win_write = req_write[cand];
                win_addr = req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[cand*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    // IDLE -> ACCESS -> DONE; the SFR bus registers double as the latched copy of the granted request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q <= IDW'(NUM_REQ - 1);
            req_done <= '0;
            rsp_rdata <= '0;
            busy <= 1'b0;
            grant_id <= '0;
            sfr_address <= '0;
            sfr_write_data <= '0;
            sfr_we <= 1'b0;
            sfr_re <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_valid) begin
                    state_q <= ACCESS;
                    grant_id <= win;
                    rr_q <= win;
                    sfr_address <= win_addr;
                    sfr_write_data <= win_wdata;
                    sfr_we <= win_write;
                    sfr_re <= !win_write;
                    busy <= 1'b1;
                end
                ACCESS: begin
                    state_q <= DONE;
                    sfr_we <= 1'b0;
                    sfr_re <= 1'b0;
                    if (sfr_re) rsp_rdata <= sfr_read_data;
                    req_done[grant_id] <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    req_done <= '0;
                    busy <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfr_access_arbiter.sv
// tb_sfr_access_arbiter: directed tests of the SFR arbiter against a behavioural register file
module tb_sfr_access_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_done;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [0:0]  grant_id;
    logic [7:0]  sfr_address;
    logic [7:0]  sfr_write_data;
    logic        sfr_we;
    logic        sfr_re;
    logic [7:0]  sfr_read_data;
    logic [7:0]  mem [256] = '{default: 8'h00};
    int          total = 0;
    int          passed = 0;
    int          lat, we_cnt, re_cnt;
    logic [7:0]  s_addr, s_data, rd;
    logic [0:0]  gid;

    sfr_access_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .busy(busy), .grant_id(grant_id),
        .sfr_address(sfr_address), .sfr_write_data(sfr_write_data),
        .sfr_we(sfr_we), .sfr_re(sfr_re), .sfr_read_data(sfr_read_data)
    );

    always #5 clk = ~clk;
    assign sfr_read_data = mem[sfr_address];
    always @(posedge clk) if (sfr_we) mem[sfr_address] <= sfr_write_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_write[id] = wr;
        req_addr[id*8 +: 8] = a;
        req_wdata[id*8 +: 8] = d;
        req_valid[id] = 1'b1;
        lat = 0; we_cnt = 0; re_cnt = 0; s_addr = 'x; s_data = 'x; rd = 'x; gid = 'x;
        while (lat < 10) begin
            tick();
            lat++;
            if (sfr_we) begin we_cnt++; s_addr = sfr_address; s_data = sfr_write_data; end
            if (sfr_re) begin re_cnt++; s_addr = sfr_address; end
            if (req_done[id]) begin rd = rsp_rdata; gid = grant_id; break; end
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({busy, req_done, grant_id} !== 4'b0) $display("FAIL reset_ctl: got busy=%b done=%b gid=%0d exp 0", busy, req_done, grant_id); else passed++;
        total++; if ({sfr_we, sfr_re} !== 2'b0) $display("FAIL reset_strobes: got we=%b re=%b exp 0", sfr_we, sfr_re); else passed++;
        total++; if ({rsp_rdata, sfr_address, sfr_write_data} !== 24'h0) $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h exp 0", rsp_rdata, sfr_address, sfr_write_data); else passed++;
    endtask

    task automatic test_write();
        run(0, 1'b1, 8'h10, 8'hA5);
        total++; if (lat !== 2) $display("FAIL wr_latency: got %0d exp 2", lat); else passed++;
        total++; if (we_cnt !== 1 || re_cnt !== 0) $display("FAIL wr_strobes: got we=%0d re=%0d exp 1/0", we_cnt, re_cnt); else passed++;
        total++; if (s_addr !== 8'h10 || s_data !== 8'hA5) $display("FAIL wr_bus: got %h<=%h exp 10<=a5", s_addr, s_data); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL wr_busy_done: got %b exp 1", busy); else passed++;
        tick();
        total++; if (busy !== 1'b0 || req_done !== 2'b00) $display("FAIL wr_idle: got busy=%b done=%b exp 0/00", busy, req_done); else passed++;
        total++; if (sfr_address !== 8'h10 || mem[8'h10] !== 8'hA5) $display("FAIL wr_hold: got addr=%h mem=%h exp 10/a5", sfr_address, mem[8'h10]); else passed++;
    endtask

    task automatic test_read();
        run(0, 1'b0, 8'h10, 8'h00);
        total++; if (lat !== 2) $display("FAIL rd_latency: got %0d exp 2", lat); else passed++;
        total++; if (re_cnt !== 1 || we_cnt !== 0) $display("FAIL rd_strobes: got we=%0d re=%0d exp 0/1", we_cnt, re_cnt); else passed++;
        total++; if (rd !== 8'hA5) $display("FAIL rd_data: got %h exp a5", rd); else passed++;
        tick();
        tick();
        total++; if (rsp_rdata !== 8'hA5) $display("FAIL rd_hold: got %h exp a5", rsp_rdata); else passed++;
    endtask

    task automatic test_two_requesters();
        int d0, d1;
        do_reset();
        d0 = -1; d1 = -1;
        req_write = 2'b11;
        req_addr = 16'h2120;
        req_wdata = 16'h2211;
        req_valid = 2'b11;
        for (int c = 1; c <= 20 && d1 < 0; c++) begin
            tick();
            if (req_done[0] && d0 < 0) begin d0 = c; req_valid[0] = 1'b0; end
            if (req_done[1] && d1 < 0) begin d1 = c; req_valid[1] = 1'b0; end
        end
        req_valid = '0;
        total++; if (d0 !== 2) $display("FAIL pair_first: got done0 at %0d exp 2", d0); else passed++;
        total++; if (d1 - d0 !== 3) $display("FAIL pair_spacing: got %0d exp 3", d1 - d0); else passed++;
        total++; if (mem[8'h20] !== 8'h11 || mem[8'h21] !== 8'h22) $display("FAIL pair_mem: got %h/%h exp 11/22", mem[8'h20], mem[8'h21]); else passed++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq;
        int n, bad, first, last;
        do_reset();
        seq = '0; n = 0; bad = 0; first = -1; last = -1;
        req_write = 2'b11;
        req_addr = 16'h3130;
        req_wdata = 16'h0201;
        req_valid = 2'b11;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            tick();
            if ((sfr_we || sfr_re || req_done != 2'b00) && !busy) bad++;
            if (sfr_we && sfr_re) bad++;
            if (req_done != 2'b00) begin
                seq[n] = grant_id;
                n++;
                if (first < 0) first = c;
                last = c;
            end
        end
        req_valid = '0;
        total++; if (n !== 6) $display("FAIL b2b_count: got %0d exp 6", n); else passed++;
        total++; if (seq !== 6'b101010) $display("FAIL b2b_order: got %b exp 101010 (bit0 first)", seq); else passed++;
        total++; if (bad !== 0) $display("FAIL b2b_busy: got %0d violations exp 0", bad); else passed++;
        total++; if (last - first !== 15) $display("FAIL b2b_rate: got %0d exp 15", last - first); else passed++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        run(1, 1'b0, 8'h10, 8'h00);
        total++; if (rd !== 8'hA5 || gid !== 1'b1) $display("FAIL mid_pre: got rdata=%h gid=%0d exp a5/1", rd, gid); else passed++;
        tick();
        req_write[1] = 1'b0;
        req_addr[15:8] = 8'h10;
        req_valid[1] = 1'b1;
        tick();
        total++; if (sfr_re !== 1'b1 || busy !== 1'b1) $display("FAIL mid_access: got re=%b busy=%b exp 1/1", sfr_re, busy); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = '0;
        total++; if (req_done !== 2'b00 || busy !== 1'b0 || rsp_rdata !== 8'h00) $display("FAIL mid_reset: got done=%b busy=%b rdata=%h exp 00/0/00", req_done, busy, rsp_rdata); else passed++;
        total++; if (sfr_re !== 1'b0 || grant_id !== 1'b0) $display("FAIL mid_reset_bus: got re=%b gid=%0d exp 0/0", sfr_re, grant_id); else passed++;
        tick();
        tick();
        total++; if (req_done !== 2'b00 || busy !== 1'b0) $display("FAIL mid_after: got done=%b busy=%b exp 00/0", req_done, busy); else passed++;
    endtask

    task automatic test_addr_edges();
        run(1, 1'b1, 8'hFF, 8'h3C);
        total++; if (s_addr !== 8'hFF || s_data !== 8'h3C || gid !== 1'b1) $display("FAIL edge_wr: got %h<=%h gid=%0d exp ff<=3c gid=1", s_addr, s_data, gid); else passed++;
        tick();
        run(1, 1'b0, 8'hFF, 8'h00);
        total++; if (rd !== 8'h3C || s_addr !== 8'hFF) $display("FAIL edge_rd_ff: got %h@%h exp 3c@ff", rd, s_addr); else passed++;
        tick();
        run(1, 1'b0, 8'h00, 8'h00);
        total++; if (rd !== 8'h00 || s_addr !== 8'h00 || gid !== 1'b1) $display("FAIL edge_rd_00: got %h@%h gid=%0d exp 00@00 gid=1", rd, s_addr, gid); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_two_requesters();
        test_back_to_back();
        test_reset_mid_access();
        test_addr_edges();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
